// File: rtl/reorder_buffer_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback from CDB_N channels, in-order retire.
// Optional operand forwarding ports are enabled by defining ROB_OPERAND_FWD_EN.
module reorder_buffer_queue #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CDB_N  = 2,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     CLOCK_50,
  input  logic                     RSTN_N,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [REG_W-1:0]         alloc_rd,
  input  logic                     alloc_is_store,
  input  logic                     alloc_is_branch,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [CDB_N-1:0]         wb_valid,
  input  logic [CDB_N*TAG_W-1:0]   wb_tag,
  input  logic [CDB_N*DATA_W-1:0]  wb_value,
  input  logic [CDB_N*ADDR_W-1:0]  wb_addr,
  input  logic [CDB_N-1:0]         wb_mispredict,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [REG_W-1:0]         commit_rd,
  output logic [DATA_W-1:0]        commit_value,
  output logic [ADDR_W-1:0]        commit_addr,
  output logic                     commit_is_store,
  output logic                     commit_is_branch,
  output logic                     commit_mispredict,
  output logic                     flush,
`ifdef ROB_OPERAND_FWD_EN
  input  logic [TAG_W-1:0]         fwd_tag [2],
  output logic                     fwd_hit [2],
  output logic [DATA_W-1:0]        fwd_value [2],
`endif
  output logic [TAG_W:0]           count
);

  localparam logic [TAG_W:0] DEPTH_C = DEPTH[TAG_W:0];

  logic              ent_valid  [DEPTH];
  logic              ent_done   [DEPTH];
  logic [REG_W-1:0]  ent_rd     [DEPTH];
  logic              ent_store  [DEPTH];
  logic              ent_branch [DEPTH];
  logic              ent_mis    [DEPTH];
  logic [DATA_W-1:0] ent_value  [DEPTH];
  logic [ADDR_W-1:0] ent_addr   [DEPTH];

  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W-1:0]  wb_tag_a [CDB_N];
  logic              alloc_fire, retire, mis_retire;

  always_comb begin
    for (int c = 0; c < CDB_N; c++) wb_tag_a[c] = wb_tag[c*TAG_W +: TAG_W];
  end

  assign commit_valid      = ent_valid[head] && ent_done[head];
  assign commit_tag        = head;
  assign commit_rd         = ent_rd[head];
  assign commit_value      = ent_value[head];
  assign commit_addr       = ent_addr[head];
  assign commit_is_store   = ent_store[head];
  assign commit_is_branch  = ent_branch[head];
  assign commit_mispredict = ent_mis[head];

  // Dispatch stalls while a mispredicted branch sits retirable at the head.
  assign alloc_ready = (count < DEPTH_C) && !(commit_valid && commit_mispredict);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire      = commit_valid && commit_ready;
  assign mis_retire  = retire && commit_mispredict;

`ifdef ROB_OPERAND_FWD_EN
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      fwd_hit[f]   = ent_valid[fwd_tag[f]] && ent_done[fwd_tag[f]];
      fwd_value[f] = ent_value[fwd_tag[f]];
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_done[i]   <= 1'b0;
        ent_rd[i]     <= '0;
        ent_store[i]  <= 1'b0;
        ent_branch[i] <= 1'b0;
        ent_mis[i]    <= 1'b0;
        ent_value[i]  <= '0;
        ent_addr[i]   <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      flush <= 1'b0;
    end else begin
      flush <= mis_retire;
      if (mis_retire) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_valid[i] <= 1'b0;
          ent_done[i]  <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_fire) begin
          ent_valid[tail]  <= 1'b1;
          ent_done[tail]   <= 1'b0;
          ent_rd[tail]     <= alloc_rd;
          ent_store[tail]  <= alloc_is_store;
          ent_branch[tail] <= alloc_is_branch;
          ent_mis[tail]    <= 1'b0;
          tail             <= tail + 1'b1;
        end
        if (retire) begin
          ent_valid[head] <= 1'b0;
          head            <= head + 1'b1;
        end
        // Descending scan: the lowest channel's write lands last and wins a tag collision.
        for (int c = CDB_N - 1; c >= 0; c--) begin
          if (wb_valid[c] && ent_valid[wb_tag_a[c]] && !ent_done[wb_tag_a[c]]) begin
            ent_done[wb_tag_a[c]]  <= 1'b1;
            ent_value[wb_tag_a[c]] <= wb_value[c*DATA_W +: DATA_W];
            ent_addr[wb_tag_a[c]]  <= wb_addr[c*ADDR_W +: ADDR_W];
            ent_mis[wb_tag_a[c]]   <= wb_mispredict[c] && ent_branch[wb_tag_a[c]];
          end
        end
        count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire};
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_queue.sv
// Directed-vector bench for reorder_buffer_queue (default build, forwarding ports absent).
module tb_reorder_buffer_queue;
  localparam int TW = 4, DW = 32, AW = 32, RW = 5, CN = 2;

  logic CLOCK_50 = 1'b0, RSTN_N = 1'b0;
  logic alloc_valid = 0, alloc_ready, alloc_is_store = 0, alloc_is_branch = 0;
  logic [RW-1:0] alloc_rd = '0;
  logic [TW-1:0] alloc_tag;
  logic [CN-1:0] wb_valid = '0, wb_mispredict = '0;
  logic [CN*TW-1:0] wb_tag = '0;
  logic [CN*DW-1:0] wb_value = '0;
  logic [CN*AW-1:0] wb_addr = '0;
  logic commit_valid, commit_ready = 0;
  logic [TW-1:0] commit_tag;
  logic [RW-1:0] commit_rd;
  logic [DW-1:0] commit_value;
  logic [AW-1:0] commit_addr;
  logic commit_is_store, commit_is_branch, commit_mispredict, flush;
  logic [TW:0] count;

  int vec_cnt = 0;
  int miscompares = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  reorder_buffer_queue dut (
    .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_is_store(alloc_is_store), .alloc_is_branch(alloc_is_branch), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
    .wb_mispredict(wb_mispredict),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_addr(commit_addr),
    .commit_is_store(commit_is_store), .commit_is_branch(commit_is_branch),
    .commit_mispredict(commit_mispredict), .flush(flush), .count(count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wb(input int ch, input int tag, input int value, input bit mis);
    wb_valid[ch]           = 1'b1;
    wb_tag[ch*TW +: TW]    = tag[TW-1:0];
    wb_value[ch*DW +: DW]  = value;
    wb_addr[ch*AW +: AW]   = value + 32'h1000;
    wb_mispredict[ch]      = mis;
  endtask

  task automatic wb_clear();
    wb_valid = '0;
    wb_mispredict = '0;
  endtask

  task automatic do_reset();
    RSTN_N = 1'b0;
    alloc_valid = 0; alloc_is_branch = 0; commit_ready = 0;
    wb_clear();
    tick();
    tick();
    RSTN_N = 1'b1;
  endtask

  initial begin
    do_reset();
    #2;
    check_val("rst_count", count, 0);
    check_val("rst_commit_valid", commit_valid, 0);
    check_val("rst_alloc_ready", alloc_ready, 1);
    check_val("rst_flush", flush, 0);

    // 1: three allocations
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd = RW'(i + 1);
      #2;
      check_val("t1_alloc_tag", alloc_tag, i);
      tick();
    end
    alloc_valid = 0;
    #2;
    check_val("t1_count", count, 3);
    check_val("t1_commit_valid", commit_valid, 0);

    // 2: out-of-order writeback, in-order commit
    wb(0, 2, 30, 0);
    tick();
    wb(0, 0, 10, 0);
    #2;
    check_val("t2_head_not_done", commit_valid, 0);
    tick();
    wb(0, 1, 20, 0);
    commit_ready = 1;
    #2;
    check_val("t2_cv0", commit_valid, 1);
    check_val("t2_rd0", commit_rd, 1);
    check_val("t2_val0", commit_value, 10);
    check_val("t2_addr0", commit_addr, 32'h100a);
    tick();
    wb_clear();
    #2;
    check_val("t2_cv1", commit_valid, 1);
    check_val("t2_rd1", commit_rd, 2);
    check_val("t2_val1", commit_value, 20);
    tick();
    #2;
    check_val("t2_rd2", commit_rd, 3);
    check_val("t2_val2", commit_value, 30);
    tick();
    commit_ready = 0;
    #2;
    check_val("t2_empty_cv", commit_valid, 0);
    check_val("t2_empty_count", count, 0);

    // 3: fill, full stall, retire one, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1; alloc_rd = RW'(i);
      #2;
      check_val("t3_alloc_tag", alloc_tag, i);
      tick();
    end
    #2;
    check_val("t3_full_count", count, 16);
    check_val("t3_full_ready", alloc_ready, 0);
    tick();
    alloc_valid = 0;
    #2;
    check_val("t3_full_hold", count, 16);
    wb(0, 0, 7, 0);
    tick();
    wb_clear();
    commit_ready = 1;
    #2;
    check_val("t3_commit_tag", commit_tag, 0);
    check_val("t3_commit_valid", commit_valid, 1);
    check_val("t3_still_full", alloc_ready, 0);
    tick();
    commit_ready = 0;
    #2;
    check_val("t3_count15", count, 15);
    check_val("t3_ready_again", alloc_ready, 1);
    alloc_valid = 1; alloc_rd = 5'd31;
    #2;
    check_val("t3_wrap_tag", alloc_tag, 0);
    tick();
    alloc_valid = 0;
    #2;
    check_val("t3_refull", count, 16);

    // 4: mispredicted branch retire flushes
    do_reset();
    alloc_valid = 1; alloc_is_branch = 1; alloc_rd = 5'd4;
    tick();
    alloc_is_branch = 0; alloc_rd = 5'd5;
    tick();
    alloc_rd = 5'd6;
    tick();
    alloc_valid = 0;
    wb(0, 0, 0, 1);
    tick();
    wb(0, 1, 55, 0);
    commit_ready = 1;
    #2;
    check_val("t4_cv", commit_valid, 1);
    check_val("t4_mis", commit_mispredict, 1);
    check_val("t4_is_branch", commit_is_branch, 1);
    check_val("t4_stall", alloc_ready, 0);
    check_val("t4_flush_pre", flush, 0);
    tick();
    commit_ready = 0;
    wb_clear();
    alloc_valid = 1; alloc_rd = 5'd9;
    #2;
    check_val("t4_flush", flush, 1);
    check_val("t4_count0", count, 0);
    check_val("t4_cv_after", commit_valid, 0);
    check_val("t4_next_tag", alloc_tag, 0);
    tick();
    alloc_valid = 0;
    #2;
    check_val("t4_flush_end", flush, 0);
    check_val("t4_count1", count, 1);

    // 5: channel priority, done-entry and freed-tag writebacks ignored, non-branch mispredict dropped
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd = RW'(10 + i);
      tick();
    end
    alloc_valid = 0;
    wb(0, 0, 100, 1);
    wb(1, 1, 101, 0);
    tick();
    wb(0, 3, 5, 0);
    wb(1, 3, 9, 0);
    tick();
    wb(0, 2, 2, 0);
    wb(1, 3, 88, 0);
    tick();
    wb_clear();
    commit_ready = 1;
    #2;
    check_val("t5_val0", commit_value, 100);
    check_val("t5_nonbranch_mis", commit_mispredict, 0);
    check_val("t5_rd0", commit_rd, 9);
    tick();
    #2;
    check_val("t5_val1", commit_value, 101);
    tick();
    #2;
    check_val("t5_val2", commit_value, 2);
    tick();
    #2;
    check_val("t5_tag3", commit_tag, 3);
    check_val("t5_prio_val", commit_value, 5);
    tick();
    commit_ready = 0;
    #2;
    check_val("t5_empty", count, 0);
    wb(0, 4, 77, 0);
    tick();
    wb_clear();
    alloc_valid = 1; alloc_rd = 5'd13;
    #2;
    check_val("t5_alloc_tag4", alloc_tag, 4);
    tick();
    alloc_valid = 0;
    #2;
    check_val("t5_freed_wb_ignored", commit_valid, 0);
    check_val("t5_count1", count, 1);

    // 6: reset with pending entries
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_rd = RW'(20 + i);
      tick();
    end
    alloc_valid = 0;
    wb(0, 4, 44, 0);
    tick();
    wb_clear();
    #2;
    check_val("t6_count5", count, 5);
    check_val("t6_cv_pre", commit_valid, 1);
    RSTN_N = 1'b0;
    #2;
    check_val("t6_rst_count", count, 0);
    check_val("t6_rst_cv", commit_valid, 0);
    check_val("t6_rst_flush", flush, 0);
    check_val("t6_rst_ready", alloc_ready, 1);
    tick();
    RSTN_N = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
